// File: rtl/fir_pkg.sv
// Shared types and constants for the time-multiplexed Q15 FIR datapath.
// Holds the data format, the sequencer state encoding and the saturation limits.
package fir_pkg;

  localparam int DATA_W = 16;
  localparam int Q_FRAC = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_NEG = 16'h8000;

  // Signed overflow of a + b = s: operands agree in sign, result does not.
  function automatic logic add_ov(input logic [DATA_W-1:0] a,
                                  input logic [DATA_W-1:0] b,
                                  input logic [DATA_W-1:0] s);
    return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
  endfunction

endpackage

// File: rtl/fir_q15_mul.sv
// Combinational 16x16 signed Q15 multiply; full product shifted right 15 (floor), low 16 bits kept.
// Zero latency, no flow control.
module fir_q15_mul
  import fir_pkg::*;
(
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] p
);

  logic signed [2*DATA_W-1:0] full;

  assign full = a * b;
  assign p    = DATA_W'(full >>> Q_FRAC);

endmodule

// File: rtl/fir_ripple_add.sv
// 16-bit ripple-carry adder used by the accumulate stage; combinational, no flow control.
// Carry-out is not produced: overflow is judged from operand and sum MSBs by the caller.
module fir_ripple_add
  import fir_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] s
);

  logic [DATA_W-1:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < DATA_W; i++) begin : g_fa
    assign s[i] = a[i] ^ b[i] ^ c[i];
    if (i < DATA_W - 1) begin : g_carry
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/fir_tap_mac.sv
// Time-multiplexed direct-form FIR (one tap per cycle); FIR_TAP_MAC_SATURATE_EN clamps the accumulator.
// Accept->out_valid NTAPS+1 cycles; result held until out_ready, in_ready low while busy.
module fir_tap_mac
  import fir_pkg::*;
#(
  parameter int  NTAPS = 4,
  localparam int TAPW  = $clog2(NTAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              coef_we,
  input  logic [TAPW-1:0]   coef_addr,
  input  logic [DATA_W-1:0] coef_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ov,
  output logic              busy
);

  localparam int KW = $clog2(NTAPS + 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] x_q [NTAPS];
  logic [DATA_W-1:0] x_d [NTAPS];
  logic [DATA_W-1:0] coef_q [NTAPS];
  logic [DATA_W-1:0] coef_d [NTAPS];
  logic [TAPW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [TAPW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [KW-1:0]     k_q, k_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] prod_q, prod_d;
  logic              ovf_q, ovf_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_ov_q, out_ov_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;

  logic [TAPW-1:0]   tap_idx;
  logic [DATA_W-1:0] prod;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] acc_next;
  logic              step_ov;

  // The product is registered, so the adder always consumes the previous tap's product;
  // the drain step at k == NTAPS performs no multiply.
  assign tap_idx = (int'(k_q) < NTAPS) ? TAPW'(k_q) : '0;

  fir_q15_mul u_mul (
    .a (coef_q[tap_idx]),
    .b (x_q[rd_ptr_q]),
    .p (prod)
  );

  fir_ripple_add u_add (
    .a (acc_q),
    .b (prod_q),
    .s (sum)
  );

  assign step_ov = add_ov(acc_q, prod_q, sum);

  always_comb begin
`ifdef FIR_TAP_MAC_SATURATE_EN
    acc_next = step_ov ? (acc_q[DATA_W-1] ? SAT_NEG : SAT_POS) : sum;
`else
    acc_next = sum;
`endif
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    coef_d      = coef_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    k_d         = k_q;
    acc_d       = acc_q;
    prod_d      = prod_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ov_d    = out_ov_q;

    case (state_q)
      IDLE: begin
        if (coef_we && (int'(coef_addr) < NTAPS)) begin
          coef_d[coef_addr] = coef_data;
        end
        if (in_valid) begin
          x_d[wr_ptr_q] = in_data;
          rd_ptr_d      = wr_ptr_q;
          wr_ptr_d      = (int'(wr_ptr_q) == NTAPS - 1) ? '0 : wr_ptr_q + 1'b1;
          k_d           = '0;
          acc_d         = '0;
          prod_d        = '0;
          ovf_d         = 1'b0;
          state_d       = MAC;
        end
      end
      MAC: begin
        acc_d = acc_next;
        ovf_d = ovf_q | step_ov;
        if (int'(k_q) == NTAPS) begin
          out_data_d  = acc_next;
          out_ov_d    = ovf_q | step_ov;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          prod_d   = prod;
          rd_ptr_d = (rd_ptr_q == '0) ? TAPW'(NTAPS - 1) : rd_ptr_q - 1'b1;
          k_d      = k_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i < NTAPS; i++) begin
        x_q[i]    <= '0;
        coef_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ov_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      coef_q      <= coef_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ov_q    <= out_ov_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ov    = out_ov_q;
  assign busy      = busy_q;

endmodule
